// File: rtl/gray2bin_pkg.sv
// Shared types and the golden Gray-to-binary reference for the round-robin
// Gray decoder.
package gray2bin_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  // Binary bit i is the XOR of all Gray bits at or above i. The XOR is built
  // by prefix doubling, so zero-extended narrower words decode correctly.
  function automatic logic [63:0] gray2bin_f(input logic [63:0] g);
    logic [63:0] b;
    b = g;
    for (int s = 1; s < 64; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. It searches upward from last_id_i+1,
// wraps around, and returns a one-hot grant plus the encoded winner.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_id_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_id_o
);

  always_comb begin
    int   idx;
    logic found;
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = int'(last_id_i) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (en_i && !found && req_i[IDW'(idx)]) begin
        found              = 1'b1;
        gnt_o[IDW'(idx)]   = 1'b1;
        gnt_id_o           = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/gray2bin_rr_sched.sv
// Shares one bit-serial Gray-to-binary engine among NREQ requesters. Grants
// round-robin in IDLE, decodes MSB-first in CONV, and holds the result in DONE.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is only ever raised in IDLE and never depends on
// rsp_ready; rsp_valid is high exactly while in DONE.
module gray2bin_rr_sched
  import gray2bin_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ),
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_gray,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_bin,
  output logic [IDW-1:0]        rsp_id,
  output state_e                dbg_state
);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   last_q, last_d;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_id;
  logic             req_hs;
  logic             upper_bit;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i     (req_valid),
    .last_id_i (last_q),
    .en_i      (state_q == IDLE),
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id)
  );

  assign req_ready = gnt;
  assign req_hs    = |(req_valid & gnt);
  assign rsp_valid = (state_q == DONE);
  assign rsp_bin   = bin_q;
  assign rsp_id    = id_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gray_d    = gray_q;
    bin_d     = bin_q;
    id_d      = id_q;
    last_d    = last_q;
    upper_bit = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          gray_d  = req_gray[gnt_id*WIDTH +: WIDTH];
          id_d    = gnt_id;
          last_d  = gnt_id;
          bin_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = CONV;
        end
      end
      CONV: begin
        // The MSB has no higher binary bit; it copies the Gray MSB.
        if (cnt_q != CW'(WIDTH - 1)) upper_bit = bin_q[cnt_q + 1'b1];
        bin_d[cnt_q] = gray_q[cnt_q] ^ upper_bit;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gray_q  <= '0;
      bin_q   <= '0;
      id_q    <= '0;
      last_q  <= IDW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gray_q  <= gray_d;
      bin_q   <= bin_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  a_done_matches_ref : assert property (
    @(posedge clk) disable iff (rst)
    (state_q == DONE) |-> (bin_q == WIDTH'(gray2bin_f(64'(gray_q))))
  );

endmodule
